array_result_drain: RTL and testbench

Downstream consumer of the `grammerTest` result array. Captures each 4-entry array write (address plus 32-bit word) into a local valid-tagged buffer and drains the entries in round-robin address order over a valid/ready stream. While draining it maintains a running sum and a running maximum of the delivered words, and it counts writes lost to overwrite.

---
 rtl/grammer_pkg.sv | 23 ++
 rtl/rr_pick4.sv | 33 +++
 rtl/array_result_drain.sv | 168 ++++++++++++++++
 tb/tb_array_result_drain.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grammer_pkg.sv
// grammer_pkg
// Shared definitions for consumers of the grammerTest result array.
//   ARR_DEPTH / ARR_AW : number of array entries and index width
//   ARR_DW             : word width carried by an entry
//   drain_state_t      : drain FSM states
//   arr_entry_t        : one buffered array entry {valid, data}
package grammer_pkg;

  localparam int ARR_DEPTH = 4;
  localparam int ARR_AW    = 2;
  localparam int ARR_DW    = 32;

  typedef enum logic {
    IDLE,
    SEND
  } drain_state_t;

  typedef struct packed {
    logic              valid;
    logic [ARR_DW-1:0] data;
  } arr_entry_t;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational round-robin first-set finder over a 4-entry valid vector.
//   valid : per-entry valid bits
//   start : index where the search begins (wraps modulo 4)
//   sel   : first index with valid set, searching start, start+1, ...
//   any   : at least one valid bit is set (sel is 0 when clear)
module rr_pick4
  import grammer_pkg::*;
(
  input  logic [ARR_DEPTH-1:0] valid,
  input  logic [ARR_AW-1:0]    start,
  output logic [ARR_AW-1:0]    sel,
  output logic                 any
);

  logic [ARR_AW-1:0] idx;

  // Walk from the farthest offset back to the nearest so the entry closest
  // to the start pointer is the last one to win.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = ARR_DEPTH - 1; k >= 0; k--) begin
      idx = start + ARR_AW'(k);
      if (valid[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/array_result_drain.sv
// array_result_drain
// Buffers writes to the 4-entry result array and drains them in round-robin
// address order over a valid/ready stream, accumulating a running sum and
// maximum of the delivered words and counting writes lost to overwrite.
//   clk, reset          : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : array write from the upstream stage
//   out_valid/out_ready : output handshake; out_addr/out_data the word
//   sum, max            : modulo sum and unsigned max of accepted words
//   drop_cnt, overflow  : saturating overwrite count and its sticky flag
module array_result_drain
  import grammer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DROP_W = 8
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ARR_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ARR_AW-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] max,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
);

  drain_state_t      state_q, state_d;
  arr_entry_t        ent_q [ARR_DEPTH];
  arr_entry_t        ent_d [ARR_DEPTH];
  logic [ARR_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ARR_AW-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic [ARR_DEPTH-1:0] valid_vec;
  logic [ARR_AW-1:0]    post_ptr;
  logic [ARR_AW-1:0]    idle_sel, post_sel, load_sel;
  logic                 idle_any, post_any, load, handshake;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < ARR_DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
    end
  end

  assign handshake = (state_q == SEND) && out_ready;
  // After a handshake the search restarts just past the word that left.
  assign post_ptr  = out_addr_q + 2'd1;

  rr_pick4 u_pick_idle (
    .valid (valid_vec),
    .start (rd_ptr_q),
    .sel   (idle_sel),
    .any   (idle_any)
  );

  rr_pick4 u_pick_post (
    .valid (valid_vec),
    .start (post_ptr),
    .sel   (post_sel),
    .any   (post_any)
  );

  // The loaded entry is read before the same-cycle write lands, so a write to
  // the entry being loaded re-arms it with new data instead of being a drop.
  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    rd_ptr_d   = rd_ptr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    sum_d      = sum_q;
    max_d      = max_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    load       = 1'b0;
    load_sel   = idle_sel;

    case (state_q)
      IDLE: begin
        if (idle_any) begin
          load     = 1'b1;
          load_sel = idle_sel;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          sum_d    = sum_q + out_data_q;
          if (out_data_q > max_q) begin
            max_d = out_data_q;
          end
          rd_ptr_d = post_ptr;
          if (post_any) begin
            load     = 1'b1;
            load_sel = post_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_addr_d            = load_sel;
      out_data_d            = ent_q[load_sel].data;
      ent_d[load_sel].valid = 1'b0;
    end

    if (wr_en) begin
      if (ent_q[wr_addr].valid && !(load && (load_sel == wr_addr))) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end
      ent_d[wr_addr].valid = 1'b1;
      ent_d[wr_addr].data  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < ARR_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < ARR_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      rd_ptr_q   <= rd_ptr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign sum       = sum_q;
  assign max       = max_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_array_result_drain.sv
// tb_array_result_drain
// Self-checking bench for array_result_drain: a vector table for the in-order
// drain, hand-written sequences for drops, wrap-around, same-cycle load/write,
// mid-transfer reset and counter saturation, then randomized traffic compared
// against a word-level reference model.
module tb_array_result_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_addr;
  logic [31:0] out_data;
  logic [31:0] sum;
  logic [31:0] max;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  array_result_drain #(.DATA_W(32), .DROP_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .sum       (sum),
    .max       (max),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  // Reference model: the array contents, which entries are still owed to the
  // sink, the word currently on offer, and the running statistics.
  logic [31:0] m_mem [4];
  bit          m_pend [4];
  int          m_ptr;
  bit          m_busy;
  int          m_addr;
  logic [31:0] m_data;
  logic [31:0] m_sum;
  logic [31:0] m_max;
  int          m_drop;
  bit          m_ovf;

  typedef struct {
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        out_ready;
    logic        exp_valid;
    logic [1:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_sum;
    logic [31:0] exp_max;
  } vec_t;

  vec_t vecs [6];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_ptr  = 0;
    m_busy = 1'b0;
    m_addr = 0;
    m_data = '0;
    m_sum  = '0;
    m_max  = '0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endfunction

  // One clock edge of the model, using the inputs presented to that edge.
  function automatic void model_edge();
    bit hs;
    int start;
    int pick;
    hs    = m_busy && (out_ready === 1'b1);
    pick  = -1;
    start = 0;
    if (!m_busy || hs) begin
      start = hs ? (m_addr + 1) % 4 : m_ptr;
      for (int k = 0; k < 4; k++) begin
        if (pick < 0 && m_pend[(start + k) % 4]) pick = (start + k) % 4;
      end
    end
    if (hs) begin
      m_sum  = m_sum + m_data;
      if (m_data > m_max) m_max = m_data;
      m_ptr  = (m_addr + 1) % 4;
      m_busy = 1'b0;
    end
    if (pick >= 0) begin
      m_busy       = 1'b1;
      m_addr       = pick;
      m_data       = m_mem[pick];
      m_pend[pick] = 1'b0;
    end
    if (wr_en === 1'b1) begin
      if (m_pend[wr_addr]) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      m_mem[wr_addr]  = wr_data;
      m_pend[wr_addr] = 1'b1;
    end
  endfunction

  task automatic apply_stimulus(input logic we, input logic [1:0] a,
                                input logic [31:0] d, input logic rdy);
    wr_en     = we;
    wr_addr   = a;
    wr_data   = d;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset === 1'b1) model_edge();
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " out_valid"}, out_valid, m_busy);
    check_output({tag, " out_addr"},  out_addr,  m_addr[1:0]);
    check_output({tag, " out_data"},  out_data,  m_data);
    check_output({tag, " sum"},       sum,       m_sum);
    check_output({tag, " max"},       max,       m_max);
    check_output({tag, " drop_cnt"},  drop_cnt,  m_drop[7:0]);
    check_output({tag, " overflow"},  overflow,  m_ovf);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0);
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // In-order drain of four consecutive writes with the sink always ready.
    vecs[0] = '{1'b1, 2'd0, 32'd5, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0,  32'd0};
    vecs[1] = '{1'b1, 2'd1, 32'd7, 1'b1, 1'b1, 2'd0, 32'd5, 32'd0,  32'd0};
    vecs[2] = '{1'b1, 2'd2, 32'd3, 1'b1, 1'b1, 2'd1, 32'd7, 32'd5,  32'd5};
    vecs[3] = '{1'b1, 2'd3, 32'd9, 1'b1, 1'b1, 2'd2, 32'd3, 32'd12, 32'd7};
    vecs[4] = '{1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 2'd3, 32'd9, 32'd15, 32'd7};
    vecs[5] = '{1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd3, 32'd9, 32'd24, 32'd9};

    reset = 1'b1;
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0);
    #1;
    do_reset();

    check_output("reset out_valid", out_valid, 1'b0);
    check_output("reset out_data",  out_data,  32'd0);
    check_output("reset sum",       sum,       32'd0);
    check_output("reset max",       max,       32'd0);
    check_output("reset drop_cnt",  drop_cnt,  8'd0);
    check_output("reset overflow",  overflow,  1'b0);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].out_ready);
      tick();
      check_output($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d out_addr", i),  out_addr,  vecs[i].exp_addr);
      check_output($sformatf("vec%0d out_data", i),  out_data,  vecs[i].exp_data);
      check_output($sformatf("vec%0d sum", i),       sum,       vecs[i].exp_sum);
      check_output($sformatf("vec%0d max", i),       max,       vecs[i].exp_max);
    end

    // Single write latency: sampled at E, presented after E+1.
    do_reset();
    apply_stimulus(1'b1, 2'd2, 32'h10, 1'b1);
    tick();
    check_output("lat E out_valid", out_valid, 1'b0);
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b1);
    tick();
    check_output("lat E+1 out_valid", out_valid, 1'b1);
    check_output("lat E+1 out_addr",  out_addr,  2'd2);
    check_output("lat E+1 out_data",  out_data,  32'h10);
    check_output("lat E+1 sum",       sum,       32'd0);
    tick();
    check_output("lat E+2 out_valid", out_valid, 1'b0);
    check_output("lat E+2 sum",       sum,       32'h10);
    check_output("lat E+2 max",       max,       32'h10);

    // Overwrite of a buffered entry while the sink stalls.
    do_reset();
    apply_stimulus(1'b1, 2'd0, 32'h1, 1'b0);
    tick();
    apply_stimulus(1'b1, 2'd1, 32'hA, 1'b0);
    tick();
    apply_stimulus(1'b1, 2'd1, 32'hB, 1'b0);
    tick();
    check_output("drop drop_cnt",  drop_cnt,  8'd1);
    check_output("drop overflow",  overflow,  1'b1);
    check_output("drop stall out_data", out_data, 32'h1);
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b1);
    tick();
    check_output("drop next out_addr", out_addr, 2'd1);
    check_output("drop next out_data", out_data, 32'hB);
    tick();
    check_output("drop end out_valid", out_valid, 1'b0);
    check_output("drop end sum",       sum,       32'hC);

    // Wrap-around: pointer parked at 3, entries 0 and 3 pending.
    do_reset();
    apply_stimulus(1'b1, 2'd2, 32'h0, 1'b0);
    tick();
    apply_stimulus(1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    apply_stimulus(1'b1, 2'd3, 32'd2, 1'b0);
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b1);
    tick();
    check_output("wrap first out_addr", out_addr, 2'd3);
    check_output("wrap first out_data", out_data, 32'd2);
    tick();
    check_output("wrap second out_addr", out_addr, 2'd0);
    check_output("wrap second out_data", out_data, 32'hFFFF_FFFF);
    tick();
    check_output("wrap sum",       sum,       32'd1);
    check_output("wrap max",       max,       32'hFFFF_FFFF);
    check_output("wrap out_valid", out_valid, 1'b0);

    // Write to the entry being loaded on the same edge.
    do_reset();
    apply_stimulus(1'b1, 2'd1, 32'h11, 1'b0);
    tick();
    apply_stimulus(1'b1, 2'd1, 32'h22, 1'b0);
    tick();
    check_output("same out_data", out_data, 32'h11);
    check_output("same drop_cnt", drop_cnt, 8'd0);
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b1);
    tick();
    check_output("same re-valid out_addr", out_addr, 2'd1);
    check_output("same re-valid out_data", out_data, 32'h22);
    check_output("same re-valid drop_cnt", drop_cnt, 8'd0);
    tick();
    check_output("same sum", sum, 32'h33);

    // Reset asserted while a word is on offer.
    apply_stimulus(1'b1, 2'd0, 32'h7, 1'b0);
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0);
    tick();
    check_output("midrst pre out_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_output("midrst out_valid", out_valid, 1'b0);
    check_output("midrst out_data",  out_data,  32'd0);
    check_output("midrst sum",       sum,       32'd0);
    check_output("midrst max",       max,       32'd0);
    tick();
    reset = 1'b1;
    apply_stimulus(1'b1, 2'd3, 32'h44, 1'b1);
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b1);
    tick();
    check_output("midrst fresh out_valid", out_valid, 1'b1);
    check_output("midrst fresh out_addr",  out_addr,  2'd3);
    check_output("midrst fresh out_data",  out_data,  32'h44);

    // Drop counter saturation.
    do_reset();
    apply_stimulus(1'b1, 2'd0, 32'h1, 1'b0);
    tick();
    apply_stimulus(1'b1, 2'd1, 32'h0, 1'b0);
    tick();
    for (int i = 1; i <= 300; i++) begin
      apply_stimulus(1'b1, 2'd1, i, 1'b0);
      tick();
      if (i == 254) check_output("sat 254 drop_cnt", drop_cnt, 8'hFE);
    end
    check_output("sat drop_cnt", drop_cnt, 8'hFF);
    check_output("sat overflow", overflow, 1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    check_model("rand reset");
    for (int c = 0; c < 500; c++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                      : 32'($urandom_range(0, 1000));
      apply_stimulus($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), d,
                     $urandom_range(0, 99) < 55);
      tick();
      check_model($sformatf("rand c%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
